fifo_collect: RTL
=================

FIFO_COLLECT -- requirements
Module: fifo_collect

Interface
REQ-001 Parameter BITS, default 64, width of one entry.
REQ-002 Parameter DEPTH, default 8, entries per batch (DEPTH >= 2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 clr  input  1  synchronous clear, abandons current batch.
REQ-007 in_valid  input  1  d holds a valid entry.
REQ-008 in_ready  output  1  block can accept d this cycle.
REQ-009 d  input  BITS  serial entry in.
REQ-010 in_last  input  1  qualifies d as final entry of a short batch.
REQ-011 out_valid  output  1  out_array holds a complete batch.
REQ-012 out_ready  input  1  consumer takes the batch this cycle.
REQ-013 out_array  output  BITS x DEPTH (unpacked [DEPTH-1:0])  parallel batch out.
REQ-014 count  output  $clog2(DEPTH+1)  entries currently held (0..DEPTH).

Function
REQ-015 Accept event = in_valid && in_ready at a rising edge; output handshake = out_valid && out_ready.
REQ-016 Storage SHALL be a DEPTH-entry shift register; on each shift, d enters index DEPTH-1 and all others move down one index ({d, regs[DEPTH-1:1]}).
REQ-017 After a complete batch, out_array[i] SHALL be the i-th accepted entry of that batch (first-received at index 0).
REQ-018 State machine SHALL have states FILL, PAD, FULL; reset state FILL.
REQ-019 FILL: in_ready=1, out_valid=0; each accept shifts d in and increments count.
REQ-020 FILL -> FULL when an accept brings count to DEPTH (regardless of in_last).
REQ-021 FILL -> PAD when the accepted entry has in_last=1 and new count < DEPTH.
REQ-022 in_last with in_valid=0 SHALL be ignored.
REQ-023 PAD: in_ready=0, out_valid=0; each cycle shifts in all-zero entry and increments count; PAD -> FULL on the shift that makes count DEPTH.
REQ-024 FULL: out_valid=1; in_ready SHALL equal out_ready (combinational).
REQ-025 FULL without handshake: out_array and count SHALL hold stable.
REQ-026 FULL with handshake and no accept: count -> 0, state -> FILL, registers unchanged.
REQ-027 FULL with handshake and simultaneous accept: d shifted in, count -> 1 (or PAD if in_last=1 and DEPTH>1, count 1), state -> FILL/PAD, no entry lost.
REQ-028 count SHALL never exceed DEPTH and never wrap.
REQ-029 out_array contents SHALL be don't-care while out_valid=0.
REQ-030 clr=1 (any state): next cycle count=0, state FILL, all entries 0; clr takes priority over accept and handshake; an accept in that cycle is discarded.
REQ-031 Latency: out_valid SHALL rise the cycle after the DEPTH-th shift (accept or pad).

Reset
REQ-032 While rst=1: all entries 0, count=0, state FILL, out_valid=0, in_ready=1.
REQ-033 rst asserted mid-batch or in FULL SHALL discard all held data immediately, without waiting for clk.
REQ-034 First accept permitted on first rising edge after rst deasserts.

Verification (BITS=8, DEPTH=4)
REQ-035 Feed 0x11,0x22,0x33,0x44 back-to-back, out_ready=0 -> out_valid=1 next cycle, out_array[0..3]=11,22,33,44, in_ready=0, count=4 held.
REQ-036 Feed 0xA1,0xA2 with in_last on 0xA2 -> in_ready=0 for 2 cycles, then out_array=A1,A2,00,00, out_valid=1.
REQ-037 FULL with out_ready=1 and in_valid=1 d=0x55 same cycle -> out_valid=0, count=1; after 0x66,0x77,0x88 out_array=55,66,77,88.
REQ-038 clr asserted with count=3 and in_valid=1 -> count=0, out_valid=0; next 4 accepts form clean batch.
REQ-039 rst pulsed asynchronously in FULL between edges -> out_valid and count drop to 0 without a clock edge.
REQ-040 Random in_valid/out_ready stalls over 1000 batches -> every batch matches scoreboard order, no entry dropped or duplicated, count <= 4 always.

Source files
------------

// File: rtl/fifo_collect_if.sv
// Bundles the serial-in / batch-out handshake of fifo_collect.
interface fifo_collect_if #(
  parameter int unsigned BITS  = 64,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] d;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_array [DEPTH-1:0];
  logic [CW-1:0]   count;

  // Producer/consumer side
  modport master (
    output clr, in_valid, d, in_last, out_ready,
    input  in_ready, out_valid, out_array, count
  );

  // Collector side
  modport slave (
    input  clr, in_valid, d, in_last, out_ready,
    output in_ready, out_valid, out_array, count
  );
endinterface

// File: rtl/fifo_collect.sv
// Collects serial entries into a DEPTH-wide parallel batch; short batches
// (closed by in_last) are zero-padded before being presented.
module fifo_collect #(
  parameter int unsigned BITS  = 64,
  parameter int unsigned DEPTH = 8
) (
  input logic          clk,
  input logic          rst,
  fifo_collect_if.slave fc
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {FILL, PAD, FULL} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            out_valid_q;
  logic [BITS-1:0] regs [DEPTH-1:0];

  logic            in_ready_c;
  logic            shift_c;
  logic [BITS-1:0] shift_d_c;
  logic [CW-1:0]   cnt_inc_c;

  // In FULL the batch slot frees up in the same cycle the consumer takes it
  assign in_ready_c = (state == FILL) || ((state == FULL) && fc.out_ready);
  assign cnt_inc_c  = cnt + CNT_ONE;

  // Shift enable and the value entering the top of the shift register
  always_comb begin
    shift_c   = 1'b0;
    shift_d_c = '0;
    case (state)
      FILL: begin
        shift_c   = fc.in_valid;
        shift_d_c = fc.d;
      end
      PAD: begin
        shift_c   = 1'b1;
        shift_d_c = '0;
      end
      FULL: begin
        shift_c   = fc.in_valid && fc.out_ready;
        shift_d_c = fc.d;
      end
      default: begin
        shift_c   = 1'b0;
        shift_d_c = '0;
      end
    endcase
  end

  // Entry shift register: new entries enter at the top and move down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (fc.clr) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (shift_c) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) regs[i] <= regs[i+1];
      regs[DEPTH-1] <= shift_d_c;
    end
  end

  // Batch state machine with occupancy count and registered out_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else if (fc.clr) begin
      state       <= FILL;
      cnt         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (fc.in_valid) begin
            cnt <= cnt_inc_c;
            if (cnt_inc_c == CNT_FULL) begin
              state       <= FULL;
              out_valid_q <= 1'b1;
            end else if (fc.in_last) begin
              state <= PAD;
            end
          end
        end
        PAD: begin
          cnt <= cnt_inc_c;
          if (cnt_inc_c == CNT_FULL) begin
            state       <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (fc.out_ready) begin
            out_valid_q <= 1'b0;
            if (fc.in_valid) begin
              cnt   <= CNT_ONE;
              state <= fc.in_last ? PAD : FILL;
            end else begin
              cnt   <= '0;
              state <= FILL;
            end
          end
        end
        default: begin
          state       <= FILL;
          cnt         <= '0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Parallel batch view of the shift register
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) fc.out_array[i] = regs[i];
  end

  assign fc.in_ready  = in_ready_c;
  assign fc.out_valid = out_valid_q;
  assign fc.count     = cnt;

endmodule
